// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I load/store path: funct3 codes,
// load/store unit state encoding and access-size decode.
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } acc_size_t;

   // funct3[1:0] encodes the access width for both loads and stores
   function automatic acc_size_t f3_size(input logic [2:0] funct3);
      return acc_size_t'(funct3[1:0]);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables,
// lane-replicated store data, load extract/extend and access legality.
module lsu_align
   import rv32_mem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data,
   output logic        bad
);

   acc_size_t   size;
   logic        illegal;
   logic        misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign size = f3_size(funct3);

   // byte enables per size, store data replicated across all lanes
   always_comb begin
      be         = '0;
      lane_wdata = '0;
      case (size)
         SZ_BYTE: begin
            be         = 4'b0001 << offset;
            lane_wdata = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be         = 4'b0011 << offset;
            lane_wdata = {2{wdata[15:0]}};
         end
         SZ_WORD: begin
            be         = 4'b1111;
            lane_wdata = wdata;
         end
         default: ;
      endcase
      if (!we) lane_wdata = '0;
   end

   // illegal funct3 and natural-alignment check
   always_comb begin
      if (we) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      else    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misaligned = ((size == SZ_HALF) && offset[0]) ||
                   ((size == SZ_WORD) && (offset != 2'b00));
      bad = illegal || misaligned;
   end

   // pick the addressed byte/half from the read word and extend it
   always_comb begin
      byte_sel  = 8'(rdata >> {offset, 3'b000});
      half_sel  = 16'(rdata >> {offset[1], 4'b0000});
      load_data = '0;
      case (size)
         SZ_BYTE: load_data = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
         SZ_HALF: load_data = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
         SZ_WORD: load_data = rdata;
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: takes the ALU effective address plus rs2/funct3, runs one
// req/ack bus access at a time and returns an extended load value or store
// completion, flagging misaligned, illegal-funct3 and timed-out accesses.
module load_store_unit
   import rv32_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t    state;
   logic [CW-1:0] wait_cnt;
   logic [2:0]    cap_funct3;
   logic [1:0]    cap_offset;
   logic          sel_we;
   logic [2:0]    sel_funct3;
   logic [1:0]    sel_offset;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata;
   logic [31:0]   al_load;
   logic          al_bad;
   logic          timed_out;

   // IDLE decodes the incoming request; WAIT decodes the captured access
   always_comb begin
      if (state == IDLE) begin
         sel_we     = req_we;
         sel_funct3 = req_funct3;
         sel_offset = req_addr[1:0];
      end else begin
         sel_we     = mem_we;
         sel_funct3 = cap_funct3;
         sel_offset = cap_offset;
      end
   end

   lsu_align u_align (
      .we         (sel_we),
      .funct3     (sel_funct3),
      .offset     (sel_offset),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .be         (al_be),
      .lane_wdata (al_wdata),
      .load_data  (al_load),
      .bad        (al_bad)
   );

   // this WAIT cycle is the TIMEOUT_CYCLES-th without an ack
   assign timed_out = (TIMEOUT_CYCLES != 0) &&
                      ((wait_cnt + CW'(1)) == CW'(TIMEOUT_CYCLES));

   // access FSM with registered bus and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         wait_cnt   <= '0;
         cap_funct3 <= '0;
         cap_offset <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  cap_funct3 <= req_funct3;
                  cap_offset <= req_addr[1:0];
                  resp_rd    <= req_rd;
                  req_ready  <= 1'b0;
                  wait_cnt   <= '0;
                  if (al_bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_data  <= '0;
                  end else begin
                     state     <= WAIT;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= al_be;
                     mem_wdata <= al_wdata;
                  end
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_data  <= mem_we ? '0 : al_load;
               end else if (timed_out) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               mem_req    <= 1'b0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions with literal expectations
// plus a transaction-level model checked against the outputs every cycle.
module tb_load_store_unit;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_err   (resp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [1:0] k);
      int n;
      if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
      n = 1 << f3[1:0];
      return (int'(k) % n) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] k);
      int n;
      n = 1 << f3[1:0];
      return 4'(((1 << n) - 1) << k);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
      case (f3[1:0])
         2'd0:    return {4{w[7:0]}};
         2'd1:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] k, input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = rd >> (8 * k);
      h = rd >> (16 * (k / 2));
      case (f3)
         3'd0:    return 32'($signed(b[7:0]));
         3'd4:    return 32'(b[7:0]);
         3'd1:    return 32'($signed(h[15:0]));
         3'd5:    return 32'(h[15:0]);
         default: return rd;
      endcase
   endfunction

   logic        e_req = 1'b0, e_ready = 1'b1, e_resp = 1'b0, e_zero = 1'b0, started = 1'b0;
   logic        e_we = 1'b0, e_err = 1'b0;
   logic [2:0]  e_f3 = '0;
   logic [1:0]  e_k = '0;
   logic [31:0] e_addr = '0, e_wd = '0, e_data = '0;
   logic [3:0]  e_be = '0;
   logic [4:0]  e_rd = '0;
   int          waited = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("req_ready", req_ready, e_ready);
         chk("mem_req", mem_req, e_req);
         chk("resp_valid", resp_valid, e_resp);
         if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", mem_be, e_be);
            chk("mem_wdata", mem_wdata, e_wd);
         end
         if (e_resp) begin
            chk("resp_data", resp_data, e_data);
            chk("resp_err", resp_err, e_err);
            chk("resp_rd", resp_rd, e_rd);
         end
         if (e_zero) begin
            chk("rst mem_we", mem_we, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst mem_be", mem_be, 0);
            chk("rst mem_wdata", mem_wdata, 0);
            chk("rst resp_data", resp_data, 0);
            chk("rst resp_err", resp_err, 0);
            chk("rst resp_rd", resp_rd, 0);
         end
      end
      e_zero = 1'b0;
      if (rst) begin
         started = 1'b1;
         e_req = 1'b0; e_ready = 1'b1; e_resp = 1'b0; e_zero = 1'b1;
      end else if (e_resp) begin
         e_resp = 1'b0; e_ready = 1'b1;
      end else if (e_req) begin
         waited++;
         if (mem_ack) begin
            e_req = 1'b0; e_resp = 1'b1; e_err = 1'b0;
            e_data = e_we ? 32'd0 : m_load(e_f3, e_k, mem_rdata);
         end else if (waited == TO) begin
            e_req = 1'b0; e_resp = 1'b1; e_err = 1'b1; e_data = 32'd0;
         end
      end else if (e_ready && req_valid) begin
         e_ready = 1'b0;
         e_rd = req_rd; e_we = req_we; e_f3 = req_funct3; e_k = req_addr[1:0];
         if (!m_legal(req_we, req_funct3, req_addr[1:0])) begin
            e_resp = 1'b1; e_err = 1'b1; e_data = 32'd0;
         end else begin
            e_req = 1'b1; waited = 0;
            e_addr = req_addr & ~32'd3;
            e_be = m_be(req_funct3, req_addr[1:0]);
            e_wd = req_we ? m_wdata(req_funct3, req_wdata) : 32'd0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   // ack_cyc: ack in the ack_cyc-th cycle of mem_req (1 = zero wait, 0 = never)
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input int ack_cyc,
                      input logic [31:0] rdata, input logic [31:0] x_data,
                      input logic x_err, input int x_lat);
      int n, lat, k;
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; k = 0;
      while (!resp_valid && lat < 100) begin
         if (mem_req) begin
            k++;
            if (k == ack_cyc) begin
               mem_ack = 1'b1; mem_rdata = rdata;
               last_addr = mem_addr; last_be = mem_be;
               last_wdata = mem_wdata; last_we = mem_we;
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         lat++;
      end
      chk("resp arrives", resp_valid, 1);
      if (resp_valid) begin
         chk("lit resp_data", resp_data, x_data);
         chk("lit resp_err", resp_err, x_err);
         chk("lit resp_rd", resp_rd, rd);
         chk("lit latency", lat, x_lat);
      end
   endtask

   int npulse;
   int idx;
   logic acc;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset req_ready", req_ready, 1);
      chk("reset mem_req", mem_req, 0);
      chk("reset resp_valid", resp_valid, 0);

      // SB to lane 3, zero-wait
      txn(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd3, 1, 32'h0, 32'h0, 1'b0, 1);
      chk("sb mem_addr", last_addr, 32'h0000_1000);
      chk("sb mem_be", last_be, 4'b1000);
      chk("sb mem_wdata", last_wdata, 32'hA5A5_A5A5);
      chk("sb mem_we", last_we, 1);
      // LB vs LBU
      txn(1'b0, 3'd0, 32'h0000_2002, 32'h0, 5'd7, 1, 32'h0080_FF00, 32'hFFFF_FF80, 1'b0, 1);
      txn(1'b0, 3'd4, 32'h0000_2002, 32'h0, 5'd9, 1, 32'h0080_FF00, 32'h0000_0080, 1'b0, 1);
      // LH upper half, then misaligned LW
      txn(1'b0, 3'd1, 32'h0000_3002, 32'h0, 5'd10, 1, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 1);
      txn(1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd11, 1, 32'h0, 32'h0, 1'b1, 0);
      // illegal funct3 for load and store, misaligned SH
      txn(1'b0, 3'd3, 32'h0000_3000, 32'h0, 5'd12, 1, 32'h0, 32'h0, 1'b1, 0);
      txn(1'b1, 3'd4, 32'h0000_3000, 32'h0, 5'd13, 1, 32'h0, 32'h0, 1'b1, 0);
      txn(1'b1, 3'd1, 32'h0000_0011, 32'h0, 5'd14, 1, 32'h0, 32'h0, 1'b1, 0);
      // bus stalls: ack after 5, never, on the 16th cycle
      txn(1'b0, 3'd2, 32'h0000_4000, 32'h0, 5'd15, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5);
      txn(1'b0, 3'd2, 32'h0000_4004, 32'h0, 5'd16, 0, 32'h0, 32'h0, 1'b1, 16);
      txn(1'b0, 3'd5, 32'h0000_4006, 32'h0, 5'd17, 16, 32'hCAFE_0000, 32'h0000_CAFE, 1'b0, 16);
      // SH to upper half, LB positive byte
      txn(1'b1, 3'd1, 32'h0000_5002, 32'h1234_BEEF, 5'd18, 2, 32'h0, 32'h0, 1'b0, 2);
      chk("sh mem_addr", last_addr, 32'h0000_5000);
      chk("sh mem_be", last_be, 4'b1100);
      chk("sh mem_wdata", last_wdata, 32'hBEEF_BEEF);
      txn(1'b0, 3'd0, 32'h0000_5001, 32'h0, 5'd19, 1, 32'h0000_7F00, 32'h0000_007F, 1'b0, 1);

      // reset in the middle of WAIT, then a stray ack
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_6000; req_rd = 5'd20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-rst mem_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post-rst mem_req", mem_req, 0);
      chk("post-rst req_ready", req_ready, 1);
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stray ack resp_valid", resp_valid, 0);
         @(posedge clk); #1;
      end

      // three back-to-back SW with req_valid held high
      npulse = 0; idx = 0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h0000_7000; req_wdata = 32'h0A0A_0001; req_rd = 5'd1;
      for (int c = 0; c < 60 && npulse < 3; c++) begin
         acc = req_ready && req_valid;
         mem_ack = mem_req;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               req_addr = 32'h0000_7000 + 32'(4 * idx);
               req_wdata = 32'h0A0A_0001 + 32'(idx);
               req_rd = 5'(idx + 1);
            end else begin
               req_valid = 1'b0;
            end
         end
         if (resp_valid) begin
            chk("b2b order rd", resp_rd, 5'(npulse + 1));
            npulse++;
         end
      end
      chk("b2b pulse count", npulse, 3);
      repeat (4) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
      $fatal(1);
   end

endmodule
